// File: rtl/ascon_beat_serializer.sv
// ascon_beat_serializer: takes a counted run of words from the ASCON word FIFO
// and sends each word as DATA_WIDTH/BEAT_WIDTH beats, low beat first, on a
// valid/ready stream. It marks the final beat of the run and pulses done for one
// cycle when the run is complete.
module ascon_beat_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int BEAT_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_pop_o,
    output logic [BEAT_WIDTH-1:0] beat_o,
    output logic                  beat_valid_o,
    input  logic                  beat_ready_i,
    output logic                  beat_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LEN_WIDTH-1:0]  words_sent_o
);

    localparam int BPW   = DATA_WIDTH / BEAT_WIDTH;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(BPW - 1);
    localparam logic [IDX_W-1:0]     IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [DATA_WIDTH-1:0]  word_r;
    logic [LEN_WIDTH-1:0]   remaining_r;
    logic [IDX_W-1:0]       beat_idx_r;
    logic [LEN_WIDTH-1:0]   words_sent_r;

    logic                   pop_s;
    logic                   handshake_s;
    logic                   word_end_s;
    logic [BEAT_WIDTH-1:0]  beat_sel_s;
    logic [BEAT_WIDTH-1:0]  beat_lane_s [BPW];

    // Split the held word into its beat lanes for the output mux.
    for (genvar g = 0; g < BPW; g++) begin : g_lane
        assign beat_lane_s[g] = word_r[g*BEAT_WIDTH +: BEAT_WIDTH];
    end

    // Decode pop/handshake strobes and select the current beat.
    always_comb begin
        pop_s       = (state_r == ST_FETCH) && !fifo_empty_i && !flush_i;
        handshake_s = (state_r == ST_SEND) && beat_ready_i;
        word_end_s  = (beat_idx_r == IDX_LAST);
        beat_sel_s  = beat_lane_s[beat_idx_r];
    end

    // Next-state logic; flush overrides everything, including a pending start.
    always_comb begin
        state_next_s = state_r;
        if (flush_i) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        state_next_s = (len_i == LEN_ZERO) ? ST_DONE : ST_FETCH;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (!fifo_empty_i) begin
                        state_next_s = ST_SEND;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end
                ST_SEND: begin
                    if (handshake_s && word_end_s) begin
                        state_next_s = (remaining_r == LEN_ONE) ? ST_DONE : ST_FETCH;
                    end else begin
                        state_next_s = ST_SEND;
                    end
                end
                ST_DONE: state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Word holding register and transfer counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r       <= {DATA_WIDTH{1'b0}};
            remaining_r  <= LEN_ZERO;
            beat_idx_r   <= IDX_ZERO;
            words_sent_r <= LEN_ZERO;
        end else if (flush_i) begin
            word_r       <= {DATA_WIDTH{1'b0}};
            remaining_r  <= LEN_ZERO;
            beat_idx_r   <= IDX_ZERO;
            words_sent_r <= LEN_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        remaining_r  <= len_i;
                        words_sent_r <= LEN_ZERO;
                    end
                end
                ST_FETCH: begin
                    if (pop_s) begin
                        word_r     <= fifo_data_i;
                        beat_idx_r <= IDX_ZERO;
                    end
                end
                ST_SEND: begin
                    if (handshake_s) begin
                        if (word_end_s) begin
                            words_sent_r <= words_sent_r + LEN_ONE;
                            remaining_r  <= remaining_r - LEN_ONE;
                        end else begin
                            beat_idx_r <= beat_idx_r + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    remaining_r <= remaining_r;
                end
            endcase
        end
    end

    assign fifo_pop_o   = pop_s;
    assign beat_valid_o = (state_r == ST_SEND);
    assign beat_o       = beat_valid_o ? beat_sel_s : {BEAT_WIDTH{1'b0}};
    assign beat_last_o  = (state_r == ST_SEND) && (remaining_r == LEN_ONE) && word_end_s;
    assign busy_o       = (state_r != ST_IDLE);
    assign done_o       = (state_r == ST_DONE) && !flush_i;
    assign words_sent_o = words_sent_r;

endmodule

// File: tb/tb_ascon_beat_serializer.sv
// Bench for ascon_beat_serializer: a transfer-level model (a FIFO queue plus a
// queue of beats still owed for the word in hand) is checked against the DUT on
// every falling edge, alongside hand-computed expectations for each scenario.
module tb_ascon_beat_serializer;

    localparam int DW  = 64;
    localparam int BW  = 32;
    localparam int LW  = 8;
    localparam int BPW = DW / BW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i = 1'b0;
    logic          start_i = 1'b0;
    logic [LW-1:0] len_i = '0;
    logic [DW-1:0] fifo_data_i = '0;
    logic          fifo_empty_i = 1'b1;
    logic          fifo_pop_o;
    logic [BW-1:0] beat_o;
    logic          beat_valid_o;
    logic          beat_ready_i = 1'b0;
    logic          beat_last_o;
    logic          busy_o;
    logic          done_o;
    logic [LW-1:0] words_sent_o;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // bench FIFO and transfer model
    logic [DW-1:0] fq[$];
    logic [BW-1:0] m_beats[$];
    bit            m_active = 1'b0;
    bit            m_done   = 1'b0;
    int            m_left   = 0;
    int            m_sent   = 0;

    // observations for hand-computed checks
    logic [BW-1:0] got_beats[$];
    int            pop_cyc[$];
    int            last_cyc[$];
    int            done_cyc = -1;

    ascon_beat_serializer #(.DATA_WIDTH(DW), .BEAT_WIDTH(BW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .start_i(start_i), .len_i(len_i),
        .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_pop_o(fifo_pop_o),
        .beat_o(beat_o), .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i),
        .beat_last_o(beat_last_o), .busy_o(busy_o), .done_o(done_o),
        .words_sent_o(words_sent_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty_i = (fq.size() == 0);
        fifo_data_i  = (fq.size() == 0) ? '0 : fq[0];
    endtask

    task automatic model_reset();
        m_beats.delete();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_left   = 0;
        m_sent   = 0;
    endtask

    // One clock edge of the transfer model, using the inputs held across the edge.
    task automatic model_step();
        logic [DW-1:0] w;
        if (!rst_n || flush_i) begin
            model_reset();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_active) begin
            if (m_beats.size() == 0) begin
                if (fq.size() != 0) begin
                    w = fq.pop_front();
                    for (int i = 0; i < BPW; i++) m_beats.push_back(w[i*BW +: BW]);
                end
            end else if (beat_ready_i) begin
                void'(m_beats.pop_front());
                if (m_beats.size() == 0) begin
                    m_sent++;
                    m_left--;
                    if (m_left == 0) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end
        end else if (start_i) begin
            m_sent = 0;
            if (len_i == '0) m_done = 1'b1;
            else begin
                m_active = 1'b1;
                m_left   = int'(len_i);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        refresh();
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            tick();
            if (done_o) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: done_o not seen within %0d cycles", name, max_cycles);
        end
    endtask

    task automatic expect_beat(input string name, input int i, input logic [BW-1:0] v);
        chk(name, (i < got_beats.size()) ? {32'd0, got_beats[i]} : 64'hFFFF_FFFF_FFFF_FFFF,
            {32'd0, v});
    endtask

    task automatic clear_obs();
        got_beats.delete();
        pop_cyc.delete();
        last_cyc.delete();
        done_cyc = -1;
    endtask

    // Per-cycle compare of every DUT output against the model.
    initial forever begin
        @(negedge clk);
        chk("pop",   fifo_pop_o,   m_active && m_beats.size() == 0 && fq.size() != 0 && !flush_i);
        chk("valid", beat_valid_o, m_beats.size() != 0);
        chk("beat",  beat_o,       (m_beats.size() != 0) ? {32'd0, m_beats[0]} : 64'd0);
        chk("last",  beat_last_o,  m_beats.size() == 1 && m_left == 1);
        chk("busy",  busy_o,       m_active || m_done);
        chk("done",  done_o,       m_done && !flush_i);
        chk("sent",  words_sent_o, m_sent);
        if (beat_valid_o && beat_ready_i && !flush_i) got_beats.push_back(beat_o);
        if (fifo_pop_o)  pop_cyc.push_back(cyc);
        if (beat_last_o) last_cyc.push_back(cyc);
        if (done_o)      done_cyc = cyc;
    end

    initial begin
        int c0;
        // reset state
        #1;
        chk("rst_pop", fifo_pop_o, 1'b0);
        chk("rst_valid", beat_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_sent", words_sent_o, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // two words, ready held high
        clear_obs();
        fq.push_back(64'h1111_2222_3333_4444);
        fq.push_back(64'h5555_6666_7777_8888);
        refresh();
        beat_ready_i = 1'b1;
        start_i = 1'b1; len_i = 8'd2; c0 = cyc;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        expect_beat("t1_b0", 0, 32'h3333_4444);
        expect_beat("t1_b1", 1, 32'h1111_2222);
        expect_beat("t1_b2", 2, 32'h7777_8888);
        expect_beat("t1_b3", 3, 32'h5555_6666);
        chk("t1_nbeats", got_beats.size(), 4);
        chk("t1_pop0", (pop_cyc.size() > 0) ? pop_cyc[0] - c0 : -1, 1);
        chk("t1_pop1", (pop_cyc.size() > 1) ? pop_cyc[1] - c0 : -1, 4);
        chk("t1_nlast", last_cyc.size(), 1);
        chk("t1_lastcyc", (last_cyc.size() > 0) ? last_cyc[0] - c0 : -1, 6);
        chk("t1_donecyc", done_cyc - c0, 7);
        chk("t1_sent", words_sent_o, 8'd2);

        // backpressure on a single word
        clear_obs();
        fq.push_back(64'h0123_4567_89AB_CDEF);
        refresh();
        beat_ready_i = 1'b0;
        start_i = 1'b1; len_i = 8'd1;
        tick();
        start_i = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("t2_hold", beat_o, 32'h89AB_CDEF);
        chk("t2_npop", pop_cyc.size(), 1);
        beat_ready_i = 1'b1;
        wait_done("t2_done", 10);
        tick();
        expect_beat("t2_b0", 0, 32'h89AB_CDEF);
        expect_beat("t2_b1", 1, 32'h0123_4567);
        chk("t2_npop_end", pop_cyc.size(), 1);

        // empty FIFO stall
        clear_obs();
        start_i = 1'b1; len_i = 8'd1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t3_busy", busy_o, 1'b1);
        chk("t3_nopop", pop_cyc.size(), 0);
        fq.push_back(64'h0000_0000_0000_00A5);
        refresh();
        wait_done("t3_done", 10);
        tick();
        expect_beat("t3_b0", 0, 32'h0000_00A5);
        expect_beat("t3_b1", 1, 32'h0000_0000);
        chk("t3_npop", pop_cyc.size(), 1);

        // zero-length start
        clear_obs();
        start_i = 1'b1; len_i = 8'd0;
        tick();
        start_i = 1'b0;
        chk("t4_done", done_o, 1'b1);
        chk("t4_sent", words_sent_o, 8'd0);
        tick();
        chk("t4_idle", busy_o, 1'b0);
        chk("t4_nopop", pop_cyc.size(), 0);

        // start while busy is ignored
        fq.push_back(64'hCAFE_F00D_DEAD_BEEF);
        refresh();
        beat_ready_i = 1'b0;
        start_i = 1'b1; len_i = 8'd1;
        tick();
        start_i = 1'b0;
        tick();
        start_i = 1'b1; len_i = 8'd5;
        tick();
        start_i = 1'b0;
        chk("t4b_sent", words_sent_o, 8'd0);
        beat_ready_i = 1'b1;
        wait_done("t4b_done", 10);
        tick();
        chk("t4b_sent_end", words_sent_o, 8'd1);
        chk("t4b_idle", busy_o, 1'b0);

        // flush during second beat of the first of three words
        clear_obs();
        fq.push_back(64'hAAAA_0001_AAAA_0000);
        fq.push_back(64'hAAAA_0003_AAAA_0002);
        fq.push_back(64'hAAAA_0005_AAAA_0004);
        refresh();
        start_i = 1'b1; len_i = 8'd3;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t5_busy", busy_o, 1'b0);
        chk("t5_valid", beat_valid_o, 1'b0);
        chk("t5_sent", words_sent_o, 8'd0);
        chk("t5_nodone", done_cyc, -1);
        fq.delete();
        fq.push_back(64'h1357_9BDF_2468_ACE0);
        refresh();
        clear_obs();
        start_i = 1'b1; len_i = 8'd1;
        tick();
        start_i = 1'b0;
        wait_done("t5_done", 10);
        tick();
        expect_beat("t5_b0", 0, 32'h2468_ACE0);
        expect_beat("t5_b1", 1, 32'h1357_9BDF);

        // asynchronous reset in the middle of SEND
        fq.push_back(64'hFFFF_EEEE_DDDD_CCCC);
        refresh();
        beat_ready_i = 1'b0;
        start_i = 1'b1; len_i = 8'd1;
        tick();
        start_i = 1'b0;
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_valid", beat_valid_o, 1'b0);
        chk("t6_beat", beat_o, 32'd0);
        chk("t6_busy", busy_o, 1'b0);
        chk("t6_last", beat_last_o, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        clear_obs();
        fq.push_back(64'h0BAD_F00D_600D_D00D);
        refresh();
        beat_ready_i = 1'b1;
        start_i = 1'b1; len_i = 8'd1;
        tick();
        start_i = 1'b0;
        wait_done("t6_done", 10);
        tick();
        expect_beat("t6_b0", 0, 32'h600D_D00D);
        expect_beat("t6_b1", 1, 32'h0BAD_F00D);

        // maximum length run
        clear_obs();
        for (int i = 0; i < 255; i++) fq.push_back({32'(i), ~32'(i)});
        refresh();
        start_i = 1'b1; len_i = 8'd255;
        tick();
        start_i = 1'b0;
        wait_done("t7_done", 1000);
        chk("t7_sent", words_sent_o, 8'd255);
        tick();
        chk("t7_nbeats", got_beats.size(), 510);
        expect_beat("t7_last", 509, 32'd254);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
